// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory and presents each
// returned word to decode, with redirect handling and dropping of stale responses.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_OUT
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] redirect_tgt;

   assign redirect_tgt = redirect_pc & ~XLEN'(3);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_REQ;
         pc_q      <= RESET_PC;
         drop_q    <= 1'b0;
         inst_q    <= NOP_INST;
         inst_pc_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      unique case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_tgt;
            end
            // An accepted request fetches the old pc, so its response is stale under redirect
            if (mem_req_ready) begin
               state_d = ST_WAIT;
               drop_d  = redirect_valid;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d   = redirect_tgt;
               drop_d = 1'b1;
            end
            if (mem_rsp_valid) begin
               if (drop_q || redirect_valid) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  inst_d    = mem_rsp_data;
                  inst_pc_d = pc_q;
                  state_d   = ST_OUT;
               end
            end
         end
         ST_OUT: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_addr  = pc_q;
   assign inst_valid    = (state_q == ST_OUT);
   assign inst          = inst_q;
   assign inst_pc       = inst_pc_q;

   // A response outside WAIT violates the memory protocol
   rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
      mem_rsp_valid |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: each task drives one scenario and checks outputs
// at the falling edge against hand-computed values.
module tb_inst_fetch;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int vec = 0;
   int err = 0;

   inst_fetch #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Stimulus helpers only: accept the pending request / return one response
   task automatic go_wait();
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
   endtask

   task automatic go_out(input logic [31:0] d);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vec++;
      if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== RST_PC || mem_req_addr !== RST_PC) begin
         err++;
         $display("FAIL reset_state: iv=%b inst=%h ipc=%h addr=%h, want 0 %h %h %h",
                  inst_valid, inst, inst_pc, mem_req_addr, NOP, RST_PC, RST_PC);
      end
      rst = 1'b0;
      @(negedge clk);
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
         err++;
         $display("FAIL reset_first_req: v=%b addr=%h, want 1 %h", mem_req_valid, mem_req_addr, RST_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] a, d;
      for (int i = 0; i < 3; i++) begin
         a = RST_PC + 32'(4 * i);
         d = 32'h0010_0093 + 32'(i << 20);
         vec++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== a || inst_valid !== 1'b0) begin
            err++;
            $display("FAIL seq_req[%0d]: v=%b addr=%h iv=%b, want 1 %h 0", i, mem_req_valid, mem_req_addr, inst_valid, a);
         end
         go_wait();
         vec++;
         if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            err++;
            $display("FAIL seq_wait[%0d]: v=%b iv=%b, want 0 0", i, mem_req_valid, inst_valid);
         end
         go_out(d);
         vec++;
         if (inst_valid !== 1'b1 || inst !== d || inst_pc !== a || mem_req_valid !== 1'b0) begin
            err++;
            $display("FAIL seq_out[%0d]: iv=%b inst=%h ipc=%h rv=%b, want 1 %h %h 0", i, inst_valid, inst, inst_pc, mem_req_valid, d, a);
         end
         inst_ready = 1'b1;
         @(negedge clk);
         inst_ready = 1'b0;
      end
   endtask

   task automatic test_stall();
      go_wait();
      go_out(32'h0041_8233);
      for (int k = 0; k < 5; k++) begin
         vec++;
         if (inst_valid !== 1'b1 || inst !== 32'h0041_8233 || inst_pc !== 32'h8000_000C ||
             mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_000C) begin
            err++;
            $display("FAIL stall[%0d]: iv=%b inst=%h ipc=%h rv=%b addr=%h, want 1 00418233 8000000c 0 8000000c",
                     k, inst_valid, inst, inst_pc, mem_req_valid, mem_req_addr);
         end
         @(negedge clk);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) begin
         err++;
         $display("FAIL stall_release: v=%b addr=%h, want 1 80000010", mem_req_valid, mem_req_addr);
      end
   endtask

   task automatic test_redirect_wait();
      go_wait();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vec++;
         if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            err++;
            $display("FAIL rdw_wait[%0d]: rv=%b iv=%b, want 0 0", k, mem_req_valid, inst_valid);
         end
         @(negedge clk);
      end
      go_out(32'hDEAD_BEEF);
      for (int k = 0; k < 2; k++) begin
         vec++;
         if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF || mem_req_valid !== 1'b1 ||
             mem_req_addr !== 32'h8000_0100) begin
            err++;
            $display("FAIL rdw_drop[%0d]: iv=%b inst=%h rv=%b addr=%h, want 0 !deadbeef 1 80000100",
                     k, inst_valid, inst, mem_req_valid, mem_req_addr);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_out();
      go_wait();
      go_out(32'h0000_0067);
      vec++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0067 || inst_pc !== 32'h8000_0100) begin
         err++;
         $display("FAIL rdo_out: iv=%b inst=%h ipc=%h, want 1 00000067 80000100", inst_valid, inst, inst_pc);
      end
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      @(negedge clk);
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200 || inst_valid !== 1'b0) begin
         err++;
         $display("FAIL rdo_next: rv=%b addr=%h iv=%b, want 1 80000200 0", mem_req_valid, mem_req_addr, inst_valid);
      end
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0306;
      @(negedge clk);
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0304) begin
         err++;
         $display("FAIL rdr_noacc: v=%b addr=%h, want 1 80000304", mem_req_valid, mem_req_addr);
      end
      redirect_pc   = 32'h8000_0400;
      mem_req_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      mem_req_ready  = 1'b0;
      vec++;
      if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         err++;
         $display("FAIL rdr_acc: rv=%b iv=%b, want 0 0", mem_req_valid, inst_valid);
      end
      go_out(32'hBAD0_0BAD);
      vec++;
      if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0400) begin
         err++;
         $display("FAIL rdr_drop: iv=%b rv=%b addr=%h, want 0 1 80000400", inst_valid, mem_req_valid, mem_req_addr);
      end
      go_wait();
      go_out(32'h0020_0113);
      vec++;
      if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h8000_0400) begin
         err++;
         $display("FAIL rdr_fetch: iv=%b inst=%h ipc=%h, want 1 00200113 80000400", inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      vec++;
      if (mem_req_addr !== 32'hFFFF_FFFC) begin
         err++;
         $display("FAIL wrap_setup: addr=%h, want fffffffc", mem_req_addr);
      end
      go_wait();
      go_out(32'h0030_0193);
      vec++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
         err++;
         $display("FAIL wrap_out: iv=%b ipc=%h, want 1 fffffffc", inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000) begin
         err++;
         $display("FAIL wrap_next: v=%b addr=%h, want 1 00000000", mem_req_valid, mem_req_addr);
      end
   endtask

   task automatic test_reset_mid();
      go_wait();
      rst           = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      vec++;
      if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== RST_PC || mem_req_addr !== RST_PC) begin
         err++;
         $display("FAIL rst_wait_async: iv=%b inst=%h ipc=%h addr=%h, want 0 %h %h %h",
                  inst_valid, inst, inst_pc, mem_req_addr, NOP, RST_PC, RST_PC);
      end
      @(negedge clk);
      rst           = 1'b0;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
         err++;
         $display("FAIL rst_wait_restart: rv=%b addr=%h iv=%b, want 1 %h 0", mem_req_valid, mem_req_addr, inst_valid, RST_PC);
      end
      go_wait();
      go_out(32'h0050_0293);
      vec++;
      if (inst_valid !== 1'b1 || inst !== 32'h0050_0293 || inst_pc !== RST_PC) begin
         err++;
         $display("FAIL rst_refetch: iv=%b inst=%h ipc=%h, want 1 00500293 %h", inst_valid, inst, inst_pc, RST_PC);
      end
      rst = 1'b1;
      #1;
      vec++;
      if (inst_valid !== 1'b0 || inst !== NOP || mem_req_valid !== 1'b1) begin
         err++;
         $display("FAIL rst_out_async: iv=%b inst=%h rv=%b, want 0 %h 1", inst_valid, inst, mem_req_valid, NOP);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
         err++;
         $display("FAIL rst_out_restart: rv=%b addr=%h iv=%b, want 1 %h 0", mem_req_valid, mem_req_addr, inst_valid, RST_PC);
      end
   endtask

   initial begin
      rst            = 1'b1;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = 32'h0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_out();
      test_redirect_req();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

endmodule
